axil_reg_slave: RTL

- AXI4-Lite responder (slave) exposing a bank of NUM_REGS 32-bit read/write registers.
- Connects as the DUT end of the team's AXI-Lite interface: consumes AW/W/AR, produces B/R.
- Single outstanding write and single outstanding read.
- Latencies meet the bus checks: BVALID within 3 cycles of the W handshake when AW arrives no later than W; RVALID within 5 cycles of the AR handshake.

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_reg_bank.sv | 48 ++++
 rtl/axil_reg_slave.sv | 133 +++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and widths for the register-slave slice.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axil_resp_t;

  // Byte address falls inside the register window; addr[1:0] never affects the result.
  function automatic logic addr_in_range(input logic [AXIL_ADDR_W-1:0] addr,
                                         input int num_regs);
    return addr < AXIL_ADDR_W'(num_regs * 4);
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Byte-strobed register array with a combinational read port.
// AXIL_REG_RO_ID_EN turns register 0 into a read-only ID word.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                     NUM_REGS = 8,
  parameter logic [AXIL_DATA_W-1:0] ID_VALUE = 32'hA11C_0001,
  localparam int                    IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       widx,
  input  logic [AXIL_DATA_W-1:0] wdata,
  input  logic [AXIL_STRB_W-1:0] wstrb,
  output logic                   wr_protected,
  input  logic [IDX_W-1:0]       ridx,
  output logic [AXIL_DATA_W-1:0] rdata
);

`ifdef AXIL_REG_RO_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

  assign wr_protected = ID_EN && (widx == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && !wr_protected) begin
      for (int b = 0; b < AXIL_STRB_W; b++) begin
        if (wstrb[b]) begin
          regs[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Register 0 storage still exists with the ID enabled but is never visible.
  assign rdata = (ID_EN && (ridx == '0)) ? ID_VALUE : regs[ridx];

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave over a NUM_REGS x 32-bit register bank; one write and one read in flight.
// Define AXIL_REG_RO_ID_EN to make register 0 a read-only ID returning ID_VALUE.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int                     NUM_REGS = 8,
  parameter logic [AXIL_DATA_W-1:0] ID_VALUE = 32'hA11C_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AXIL_ADDR_W-1:0] awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [AXIL_DATA_W-1:0] wdata,
  input  logic [AXIL_STRB_W-1:0] wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [AXIL_ADDR_W-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [AXIL_DATA_W-1:0] rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic                   aw_held;
  logic                   w_held;
  logic [AXIL_ADDR_W-1:0] aw_addr_q;
  logic [AXIL_DATA_W-1:0] w_data_q;
  logic [AXIL_STRB_W-1:0] w_strb_q;

  logic                   aw_hs;
  logic                   w_hs;
  logic                   ar_hs;
  logic                   commit;
  logic [AXIL_ADDR_W-1:0] wr_addr;
  logic [AXIL_DATA_W-1:0] wr_data;
  logic [AXIL_STRB_W-1:0] wr_strb;
  logic                   wr_in_range;
  logic                   wr_protected;
  axil_resp_t             wr_resp;
  logic                   rd_in_range;
  logic [AXIL_DATA_W-1:0] bank_rdata;

  assign awready = rst_n & ~aw_held & ~bvalid;
  assign wready  = rst_n & ~w_held & ~bvalid;
  assign arready = rst_n & ~rvalid;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // A held beat wins over the live bus; the live beat is used only when it handshakes now.
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_strb = w_held ? w_strb_q : wstrb;
  assign commit  = (aw_held | aw_hs) & (w_held | w_hs);

  assign wr_in_range = addr_in_range(wr_addr, NUM_REGS);
  assign rd_in_range = addr_in_range(araddr, NUM_REGS);
  assign wr_resp     = (!wr_in_range || wr_protected) ? RESP_SLVERR : RESP_OKAY;

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (commit & wr_in_range),
    .widx         (wr_addr[2 +: IDX_W]),
    .wdata        (wr_data),
    .wstrb        (wr_strb),
    .wr_protected (wr_protected),
    .ridx         (araddr[2 +: IDX_W]),
    .rdata        (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end

      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_resp;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // The bank updates on this same edge, so a colliding read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_in_range ? bank_rdata : '0;
      rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule
